// File: rtl/ysyx_25070198_pkg.sv
// ysyx_25070198_pkg: shared LSU state encoding and timeout default
package ysyx_25070198_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} lsu_state_t;
  localparam int LSU_TIMEOUT_DEFAULT = 256;
endpackage

// File: rtl/ysyx_25070198_load_fmt.sv
// ysyx_25070198_load_fmt: selects a zero-extended byte or the full word for loads
module ysyx_25070198_load_fmt (
  input  logic [31:0] word,
  input  logic [1:0]  sel,
  input  logic        is_lbu,
  output logic [31:0] rdata
);
  always_comb rdata = is_lbu ? {24'b0, word[{sel, 3'b000} +: 8]} : word;
endmodule

// File: rtl/ysyx_25070198_lsu.sv
// ysyx_25070198_lsu: load/store unit bridging exu requests to a valid/ready memory port
module ysyx_25070198_lsu
  import ysyx_25070198_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ren,
  input  logic        wen,
  input  logic [29:0] addr,
  input  logic [3:0]  wmask,
  input  logic [31:0] wdata,
  input  logic        is_lbu,
  input  logic [1:0]  sel,
  output logic        data_valid,
  output logic [31:0] rdata,
  output logic        fault,
  output logic        busy,
  output logic        mem_reqValid,
  input  logic        mem_reqReady,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_respErr
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  lsu_state_t state, state_n;
  logic          lbu_q;
  logic [1:0]    sel_q;
  logic [CW-1:0] cnt;
  logic [31:0]   fmt;
  logic          tmo;
  logic          finish;
  assign tmo          = cnt == CW'(TIMEOUT_CYCLES - 1);
  assign finish       = state == RESP && (mem_respValid || tmo);
  assign data_valid   = state == DONE;
  assign busy         = state != IDLE;
  assign mem_reqValid = state == REQ;
  ysyx_25070198_load_fmt u_fmt (
    .word   (mem_rdata),
    .sel    (sel_q),
    .is_lbu (lbu_q),
    .rdata  (fmt)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = (ren || wen) ? REQ : IDLE;
      REQ:     state_n = mem_reqReady ? RESP : REQ;
      RESP:    state_n = finish ? DONE : RESP;
      DONE:    state_n = (ren || wen) ? DONE : IDLE;
      default: state_n = IDLE;
    endcase
  end
  // mem_wen doubles as the latched access kind; wen wins when both are requested
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lbu_q     <= 1'b0;
      sel_q     <= 2'b0;
      mem_wen   <= 1'b0;
      mem_addr  <= 32'b0;
      mem_wmask <= 4'b0;
      mem_wdata <= 32'b0;
      cnt       <= '0;
      rdata     <= 32'b0;
      fault     <= 1'b0;
    end else begin
      if (state == IDLE && (ren || wen)) begin
        lbu_q     <= is_lbu;
        sel_q     <= sel;
        mem_wen   <= wen;
        mem_addr  <= {addr, 2'b00};
        mem_wmask <= wen ? wmask : 4'b0;
        mem_wdata <= wdata;
      end
      cnt <= (state == RESP) ? cnt + CW'(1) : '0;
      if (finish) begin
        fault <= mem_respValid ? mem_respErr : 1'b1;
        rdata <= (!mem_respValid || mem_respErr || mem_wen) ? 32'b0 : fmt;
      end
    end
  end
endmodule

// File: tb/tb_ysyx_25070198_lsu.sv
// tb_ysyx_25070198_lsu: table-driven scoreboard bench for the LSU
module tb_ysyx_25070198_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        ren, wen, is_lbu;
  logic [29:0] addr;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic [1:0]  sel;
  logic        data_valid, fault, busy;
  logic [31:0] rdata;
  logic        mem_reqValid, mem_reqReady, mem_wen;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid, mem_respErr;

  always #5 clk = ~clk;

  ysyx_25070198_lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .ren(ren), .wen(wen), .addr(addr), .wmask(wmask),
    .wdata(wdata), .is_lbu(is_lbu), .sel(sel), .data_valid(data_valid),
    .rdata(rdata), .fault(fault), .busy(busy), .mem_reqValid(mem_reqValid),
    .mem_reqReady(mem_reqReady), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wmask(mem_wmask), .mem_wdata(mem_wdata), .mem_respValid(mem_respValid),
    .mem_rdata(mem_rdata), .mem_respErr(mem_respErr)
  );

  typedef struct {
    logic        ren, wen;
    logic [29:0] addr;
    logic [3:0]  wmask;
    logic [31:0] wdata;
    logic        lbu;
    logic [1:0]  sel;
    logic [31:0] mrdata;
    logic        err, tmo, hold, spur;
    int          rdy_dly, resp_dly;
    logic [31:0] exp_rdata;
    logic        exp_fault, exp_mwen;
    logic [3:0]  exp_mwmask;
    int          exp_lat;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } exp_t;

  localparam int NV = 10;
  vec_t vt[NV];
  vec_t post;
  exp_t sb[$];
  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    ren = 1'b0; wen = 1'b0; addr = '0; wmask = '0; wdata = '0; is_lbu = 1'b0; sel = '0;
    mem_reqReady = 1'b0; mem_respValid = 1'b0; mem_rdata = 32'hBAD0BAD0; mem_respErr = 1'b0;
  endtask

  task automatic txn(input vec_t v);
    exp_t e;
    int cyc;
    logic real_resp, spur_resp;
    ren = v.ren; wen = v.wen; addr = v.addr; wmask = v.wmask; wdata = v.wdata;
    is_lbu = v.lbu; sel = v.sel;
    sb.push_back('{v.exp_rdata, v.exp_fault});
    cyc = 0;
    while (!data_valid && cyc < 64) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1 && !v.hold) begin ren = 1'b0; wen = 1'b0; end
      chk("req_valid", {31'b0, mem_reqValid}, {31'b0, cyc <= 1 + v.rdy_dly});
      if (mem_reqValid) begin
        chk("mem_addr", mem_addr, {v.addr, 2'b00});
        chk("mem_wen", {31'b0, mem_wen}, {31'b0, v.exp_mwen});
        chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, v.exp_mwmask});
        chk("mem_wdata", mem_wdata, v.wdata);
      end
      real_resp = !v.tmo && cyc == 2 + v.rdy_dly + v.resp_dly;
      spur_resp = v.spur && cyc <= v.rdy_dly;
      mem_reqReady  = cyc == 1 + v.rdy_dly;
      mem_respValid = real_resp || spur_resp;
      mem_rdata     = real_resp ? v.mrdata : 32'hBAD0BAD0;
      mem_respErr   = real_resp ? v.err : spur_resp;
    end
    chk("latency", cyc, v.exp_lat);
    chk("data_valid", {31'b0, data_valid}, 32'd1);
    chk("busy_done", {31'b0, busy}, 32'd1);
    mem_reqReady = 1'b0; mem_respValid = 1'b0; mem_respErr = 1'b0; mem_rdata = 32'hBAD0BAD0;
    e = sb.pop_front();
    chk("rdata", rdata, e.rdata);
    chk("fault", {31'b0, fault}, {31'b0, e.fault});
    if (v.hold) begin
      repeat (4) begin
        @(negedge clk);
        chk("hold_valid", {31'b0, data_valid}, 32'd1);
        chk("hold_noreq", {31'b0, mem_reqValid}, 32'd0);
      end
      ren = 1'b0; wen = 1'b0;
    end
    @(negedge clk);
    chk("idle_valid", {31'b0, data_valid}, 32'd0);
    chk("idle_busy", {31'b0, busy}, 32'd0);
    chk("held_rdata", rdata, e.rdata);
    chk("held_fault", {31'b0, fault}, {31'b0, e.fault});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, data_valid}, 32'd0);
    chk({tag, "_rdata"}, rdata, 32'd0);
    chk({tag, "_fault"}, {31'b0, fault}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_reqv"}, {31'b0, mem_reqValid}, 32'd0);
    chk({tag, "_mwen"}, {31'b0, mem_wen}, 32'd0);
    chk({tag, "_maddr"}, mem_addr, 32'd0);
    chk({tag, "_mwmask"}, {28'b0, mem_wmask}, 32'd0);
    chk({tag, "_mwdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    //         ren   wen   addr            wmask  wdata          lbu   sel    mrdata         err   tmo   hold  spur  rd rs exp_rdata      ef    mwen  mwmask lat
    vt[0] = '{1'b1, 1'b0, 30'h2000_0000, 4'h0, 32'h0,         1'b0, 2'd0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'hDEADBEEF, 1'b0, 1'b0, 4'h0, 3};
    vt[1] = '{1'b1, 1'b0, 30'h0000_0010, 4'hF, 32'h0,         1'b1, 2'd2, 32'h11223344, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h00000022, 1'b0, 1'b0, 4'h0, 3};
    vt[2] = '{1'b1, 1'b0, 30'h0000_0003, 4'h0, 32'h0,         1'b1, 2'd0, 32'h11223344, 1'b0, 1'b0, 1'b0, 1'b0, 1, 2, 32'h00000044, 1'b0, 1'b0, 4'h0, 6};
    vt[3] = '{1'b1, 1'b0, 30'h0000_0004, 4'h0, 32'h0,         1'b1, 2'd3, 32'hA5B6C7D8, 1'b0, 1'b0, 1'b0, 1'b0, 2, 0, 32'h000000A5, 1'b0, 1'b0, 4'h0, 5};
    vt[4] = '{1'b0, 1'b1, 30'h0000_0100, 4'h4, 32'h00AB0000, 1'b0, 2'd2, 32'h12345678, 1'b0, 1'b0, 1'b0, 1'b0, 5, 0, 32'h00000000, 1'b0, 1'b1, 4'h4, 8};
    vt[5] = '{1'b1, 1'b1, 30'h3FFF_FFFF, 4'hF, 32'h01020304, 1'b0, 2'd0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 0, 1, 32'h00000000, 1'b0, 1'b1, 4'hF, 4};
    vt[6] = '{1'b1, 1'b0, 30'h0000_0044, 4'h0, 32'h0,         1'b0, 2'd0, 32'h55555555, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 32'h00000000, 1'b1, 1'b0, 4'h0, 3};
    vt[7] = '{1'b1, 1'b0, 30'h0000_0048, 4'h0, 32'h0,         1'b0, 2'd0, 32'h77777777, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 32'h00000000, 1'b1, 1'b0, 4'h0, 10};
    vt[8] = '{1'b1, 1'b0, 30'h0000_004C, 4'h0, 32'h0,         1'b0, 2'd0, 32'h89ABCDEF, 1'b0, 1'b0, 1'b0, 1'b1, 3, 6, 32'h89ABCDEF, 1'b0, 1'b0, 4'h0, 12};
    vt[9] = '{1'b1, 1'b0, 30'h0000_0050, 4'h0, 32'h0,         1'b1, 2'd1, 32'hAABBCCDD, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 32'h000000CC, 1'b0, 1'b0, 4'h0, 3};
    post  = '{1'b1, 1'b0, 30'h2000_0001, 4'h0, 32'h0,         1'b0, 2'd0, 32'h600DF00D, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h600DF00D, 1'b0, 1'b0, 4'h0, 3};
    idle_inputs();
    rst = 1'b1;
    #1;
    chk_reset_outputs("por");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("init");
    for (int i = 0; i < NV; i++) txn(vt[i]);
    // abort a load while it waits in RESP, then deliver its response late
    ren = 1'b1; addr = 30'h0000_0123; is_lbu = 1'b0; sel = 2'd0;
    @(negedge clk);
    ren = 1'b0;
    chk("abort_reqv", {31'b0, mem_reqValid}, 32'd1);
    mem_reqReady = 1'b1;
    @(negedge clk);
    mem_reqReady = 1'b0;
    repeat (2) @(negedge clk);
    chk("abort_busy", {31'b0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("async");
    @(negedge clk);
    rst = 1'b0;
    mem_respValid = 1'b1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_respValid = 1'b0; mem_rdata = 32'hBAD0BAD0;
    chk_reset_outputs("late");
    txn(post);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ysyx_25070198_lsu.md
YSYX_25070198_LSU -- requirements
Module: ysyx_25070198_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 256, max cycles in RESP before fault.
REQ-002 SHALL have port clk  input  1  clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port ren  input  1  load request from exu.
REQ-005 SHALL have port wen  input  1  store request from exu.
REQ-006 SHALL have port addr  input  30  word address from exu.
REQ-007 SHALL have port wmask  input  4  byte-enable mask for stores.
REQ-008 SHALL have port wdata  input  32  lane-aligned store data.
REQ-009 SHALL have port is_lbu  input  1  load is byte, zero-extended.
REQ-010 SHALL have port sel  input  2  byte offset within word.
REQ-011 SHALL have port data_valid  output  1  access complete; rdata/fault valid.
REQ-012 SHALL have port rdata  output  32  formatted load result.
REQ-013 SHALL have port fault  output  1  access error or timeout.
REQ-014 SHALL have port busy  output  1  state is not IDLE.
REQ-015 SHALL have ports mem_reqValid out 1, mem_reqReady in 1, mem_wen out 1, mem_addr out 32 (byte addr, [1:0]=0), mem_wmask out 4, mem_wdata out 32.
REQ-016 SHALL have ports mem_respValid in 1, mem_rdata in 32, mem_respErr in 1.

Function
REQ-017 SHALL implement states IDLE, REQ, RESP, DONE.
REQ-018 IDLE: on ren|wen SHALL latch addr, wmask, wdata, is_lbu, sel, kind; go REQ next cycle.
REQ-019 ren and wen both high SHALL be treated as store (wen priority).
REQ-020 REQ: mem_reqValid=1 with latched fields held stable; on mem_reqReady=1 SHALL go RESP; no timeout in REQ.
REQ-021 mem_wen SHALL equal latched kind; mem_wmask SHALL be 0 for loads.
REQ-022 RESP: on mem_respValid SHALL capture rdata (formatted) and fault=mem_respErr; go DONE.
REQ-023 RESP: counter SHALL increment each cycle, cleared on RESP entry; at TIMEOUT_CYCLES-1 without respValid SHALL set fault=1, rdata=0, go DONE.
REQ-024 Load format: is_lbu -> {24'b0, byte[sel]} (sel 0 = bits 7:0, 3 = bits 31:24); else full word; store rdata = 0.
REQ-025 Fault SHALL force rdata=0.
REQ-026 DONE: data_valid=1; SHALL remain DONE while ren|wen high; go IDLE the cycle after both low.
REQ-027 mem_respValid outside RESP SHALL be ignored.
REQ-028 Minimum latency SHALL be 3 cycles request-to-data_valid (ready and respValid each immediate).
REQ-029 rdata and fault SHALL hold value from capture until next capture.
REQ-030 busy SHALL be 1 in REQ, RESP, DONE.

Reset
REQ-031 rst SHALL force IDLE asynchronously, including mid-transaction; pending memory response discarded.
REQ-032 Reset values: data_valid 0, rdata 0, fault 0, busy 0, mem_reqValid 0, mem_wen 0, mem_addr 0, mem_wmask 0, mem_wdata 0, counter 0.

Structure
REQ-033 lsu_state_t enum and TIMEOUT_CYCLES default SHALL live in shared package ysyx_25070198_pkg.
REQ-034 Load formatting SHALL be sub-module ysyx_25070198_load_fmt (combinational: word, sel, is_lbu -> rdata).
REQ-035 State, request latch, counter SHALL be registers; outputs registered or decoded from state only.

Verification
REQ-036 Load word: addr=0x20000000, ren=1, ready/resp immediate, mem_rdata=0xDEADBEEF -> mem_addr=0x80000000, data_valid cycle 3, rdata=0xDEADBEEF, fault 0.
REQ-037 lbu: sel=2, is_lbu=1, mem_rdata=0x11223344 -> rdata=0x00000022.
REQ-038 Store byte: wen=1, wmask=0x4, wdata=0x00AB0000, ready delayed 5 cycles -> fields stable 5 cycles, mem_wen=1, data_valid after respValid, rdata=0.
REQ-039 Timeout: TIMEOUT_CYCLES=8, respValid never -> fault=1, rdata=0, data_valid 8 cycles after RESP entry.
REQ-040 Reset in RESP: rst mid-wait, then late respValid -> IDLE, all outputs 0, response ignored, next load completes normally.
REQ-041 Hold: ren held 4 cycles after data_valid -> stays DONE, no second mem_reqValid; IDLE one cycle after ren low.
